// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the PC register, instruction memory and decode.
// The sequencer takes the master modport; the surrounding datapath takes slave.
interface fetch_sequencer_if;
  logic [31:0] currPC;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic        imem_ready;
  logic        imem_req;
  logic        fetch_valid;
  logic [31:0] newPC;
  logic        pc_halt;
  logic [1:0]  state;
  logic        trap;

  modport master (
    input  currPC, stall, redirect_valid, redirect_target, halt_req, resume, imem_ready,
    output imem_req, fetch_valid, newPC, pc_halt, state, trap
  );

  modport slave (
    output currPC, stall, redirect_valid, redirect_target, halt_req, resume, imem_ready,
    input  imem_req, fetch_valid, newPC, pc_halt, state, trap
  );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32I fetch front-end: drives the PC register's next value and hold, and runs the
// imem request handshake. Define PC_MISALIGN_TRAP_EN to vector misaligned redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master bus_io
);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_out_q, req_out_d;
  logic        redir_pend_q, redir_pend_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] redir_q, redir_d;

  logic        imem_req, fetch_valid, pc_halt, trap;
  logic [31:0] new_pc;
  logic        issue, complete, halt_eff;

  // Bit 32 flags a trap; bits 31:0 are the address actually loaded into the PC.
  function automatic logic [32:0] apply_redirect(input logic [31:0] tgt);
`ifdef PC_MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) return {1'b1, TRAP_VEC};
    return {1'b0, tgt};
`else
    return {1'b0, tgt & 32'hFFFF_FFFC};
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    req_out_d    = req_out_q;
    redir_pend_d = redir_pend_q;
    halt_pend_d  = halt_pend_q;
    redir_d      = redir_q;
    imem_req     = 1'b0;
    fetch_valid  = 1'b0;
    pc_halt      = 1'b1;
    trap         = 1'b0;
    new_pc       = bus_io.currPC;
    issue        = 1'b0;
    complete     = 1'b0;
    halt_eff     = 1'b0;

    unique case (state_q)
      StBoot: begin
        new_pc  = RESET_PC;
        pc_halt = reset;
        state_d = StFetch;
      end

      StFetch: begin
        issue    = req_out_q | ~bus_io.stall;
        complete = issue & bus_io.imem_ready;
        halt_eff = bus_io.halt_req | halt_pend_q;
        imem_req = issue;
        if (complete) begin
          pc_halt     = 1'b0;
          fetch_valid = ~(bus_io.redirect_valid | redir_pend_q | halt_eff);
          // A live redirect beats a pending one; a pending one beats sequential fetch.
          if (bus_io.redirect_valid) begin
            {trap, new_pc} = apply_redirect(bus_io.redirect_target);
          end else if (redir_pend_q) begin
            {trap, new_pc} = apply_redirect(redir_q);
          end else begin
            new_pc = bus_io.currPC + 32'd4;
          end
          req_out_d    = 1'b0;
          redir_pend_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (halt_eff) state_d = StHalted;
        end else if (issue) begin
          req_out_d = 1'b1;
          // Oldest redirect wins while the request is still in flight.
          if (bus_io.redirect_valid && !redir_pend_q) begin
            redir_pend_d = 1'b1;
            redir_d      = bus_io.redirect_target;
          end
          if (bus_io.halt_req) halt_pend_d = 1'b1;
        end else begin
          if (bus_io.redirect_valid) begin
            pc_halt        = 1'b0;
            {trap, new_pc} = apply_redirect(bus_io.redirect_target);
          end
          if (bus_io.halt_req) state_d = StHalted;
        end
      end

      StHalted: begin
        if (bus_io.redirect_valid) begin
          pc_halt        = 1'b0;
          {trap, new_pc} = apply_redirect(bus_io.redirect_target);
        end
        if (bus_io.resume) state_d = StFetch;
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      req_out_q    <= 1'b0;
      redir_pend_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      redir_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_out_q    <= req_out_d;
      redir_pend_q <= redir_pend_d;
      halt_pend_q  <= halt_pend_d;
      redir_q      <= redir_d;
    end
  end

  assign bus_io.imem_req    = imem_req;
  assign bus_io.fetch_valid = fetch_valid;
  assign bus_io.newPC       = new_pc;
  assign bus_io.pc_halt     = pc_halt;
  assign bus_io.state       = state_q;
  assign bus_io.trap        = trap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// stimulus checked each cycle against a behavioural model; the bench plays the PC register.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  fetch_sequencer_if bif ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        fv;
    logic        halt;
    logic        trap;
    logic [1:0]  st;
    logic [31:0] npc;
  } exp_t;

  // Model: 0 boot, 1 fetching, 2 halted.
  int          m_mode;
  bit          m_busy;
  bit          m_hpend;
  logic [31:0] m_redir[$];
  logic [31:0] cur_pc;
  exp_t        last_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [32:0] redir_result(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t % 4 != 0) return {1'b1, TRAP_VEC};
    return {1'b0, t};
`else
    return {1'b0, t - (t % 4)};
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t        e;
    logic [32:0] r;
    bit          issue;
    e.req = 1'b0; e.fv = 1'b0; e.halt = 1'b1; e.trap = 1'b0;
    e.st = 2'(m_mode); e.npc = cur_pc;
    if (reset) begin
      e.st = 2'd0; e.npc = RESET_PC;
      return e;
    end
    if (m_mode == 0) begin
      e.halt = 1'b0; e.npc = RESET_PC;
    end else if (m_mode == 2) begin
      if (bif.redirect_valid) begin
        r = redir_result(bif.redirect_target);
        e.halt = 1'b0; e.trap = r[32]; e.npc = r[31:0];
      end
    end else begin
      issue = m_busy || !bif.stall;
      e.req = issue;
      if (issue && bif.imem_ready) begin
        e.halt = 1'b0;
        e.fv = !(bif.redirect_valid || m_redir.size() != 0 || bif.halt_req || m_hpend);
        if (bif.redirect_valid) r = redir_result(bif.redirect_target);
        else if (m_redir.size() != 0) r = redir_result(m_redir[0]);
        else r = {1'b0, cur_pc + 32'd4};
        e.trap = r[32]; e.npc = r[31:0];
      end else if (!issue && bif.redirect_valid) begin
        r = redir_result(bif.redirect_target);
        e.halt = 1'b0; e.trap = r[32]; e.npc = r[31:0];
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_busy = 0; m_hpend = 0; m_redir.delete();
    cur_pc = 32'hDEAD_BEE0;
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    e = model_out();
    check("imem_req", 32'(bif.imem_req), 32'(e.req));
    check("fetch_valid", 32'(bif.fetch_valid), 32'(e.fv));
    check("pc_halt", 32'(bif.pc_halt), 32'(e.halt));
    check("trap", 32'(bif.trap), 32'(e.trap));
    check("state", 32'(bif.state), 32'(e.st));
    if (!e.halt || reset) check("newPC", bif.newPC, e.npc);
    last_e = e;
  endtask

  task automatic advance();
    bit issue;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          issue = m_busy || !bif.stall;
          if (issue && bif.imem_ready) begin
            m_busy = 0; m_redir.delete();
            if (bif.halt_req || m_hpend) begin m_mode = 2; m_hpend = 0; end
          end else if (issue) begin
            m_busy = 1;
            if (bif.redirect_valid && m_redir.size() == 0) m_redir.push_back(bif.redirect_target);
            if (bif.halt_req) m_hpend = 1;
          end else if (bif.halt_req) begin
            m_mode = 2;
          end
        end
        default: if (bif.resume) m_mode = 1;
      endcase
      if (!last_e.halt) cur_pc = last_e.npc;
    end
    #1;
    bif.currPC = cur_pc;
  endtask

  task automatic set_in(input bit st, input bit rv, input logic [31:0] rt, input bit hr,
                        input bit rs, input bit rdy);
    bif.stall = st; bif.redirect_valid = rv; bif.redirect_target = rt;
    bif.halt_req = hr; bif.resume = rs; bif.imem_ready = rdy;
  endtask

  task automatic set_pc(input logic [31:0] v);
    cur_pc = v; bif.currPC = v;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    bif.currPC = cur_pc;
    set_in(0, 0, 32'h0, 0, 0, 1);
    #1;

    // 1: reset outputs, BOOT, then sequential fetch at 0,4,8
    sample();
    check("rst imem_req", 32'(bif.imem_req), 32'd0);
    check("rst pc_halt", 32'(bif.pc_halt), 32'd1);
    check("rst newPC", bif.newPC, 32'h0);
    advance();
    reset = 1'b0;
    sample();
    check("boot state", 32'(bif.state), 32'd0);
    check("boot pc_halt", 32'(bif.pc_halt), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("seq fetch_valid", 32'(bif.fetch_valid), 32'd1);
      check("seq newPC", bif.newPC, 32'(4 * (i + 1)));
      advance();
    end

    // 2: stalled memory with a redirect in the middle of the wait
    set_pc(32'h10);
    set_in(0, 0, 32'h0, 0, 0, 0);
    sample(); check("wait1 imem_req", 32'(bif.imem_req), 32'd1); advance();
    set_in(0, 1, 32'h80, 0, 0, 0);
    sample(); check("wait2 pc_halt", 32'(bif.pc_halt), 32'd1); advance();
    set_in(1, 0, 32'h0, 0, 0, 0);
    sample(); check("wait3 imem_req held", 32'(bif.imem_req), 32'd1); advance();
    set_in(0, 0, 32'h0, 0, 0, 1);
    sample();
    check("redir fetch_valid", 32'(bif.fetch_valid), 32'd0);
    check("redir newPC", bif.newPC, 32'h80);
    advance();

    // 3: hazard stall holds the PC
    set_pc(32'h20);
    set_in(1, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      sample();
      check("stall imem_req", 32'(bif.imem_req), 32'd0);
      check("stall pc_halt", 32'(bif.pc_halt), 32'd1);
      advance();
    end
    set_in(0, 0, 32'h0, 0, 0, 1);
    sample(); check("unstall newPC", bif.newPC, 32'h24); advance();

    // 4: halt during an outstanding request, redirect while halted, resume
    set_pc(32'h40);
    set_in(0, 0, 32'h0, 0, 0, 0);
    sample(); advance();
    set_in(0, 0, 32'h0, 1, 0, 0);
    sample(); advance();
    set_in(0, 0, 32'h0, 0, 0, 1);
    sample();
    check("halt squash fetch_valid", 32'(bif.fetch_valid), 32'd0);
    check("halt squash newPC", bif.newPC, 32'h44);
    advance();
    set_in(0, 1, 32'h200, 0, 0, 1);
    sample();
    check("halted state", 32'(bif.state), 32'd2);
    check("halted redirect newPC", bif.newPC, 32'h200);
    advance();
    set_in(0, 0, 32'h0, 0, 1, 1);
    sample(); advance();
    set_in(0, 0, 32'h0, 0, 0, 1);
    sample();
    check("resume state", 32'(bif.state), 32'd1);
    check("resume newPC", bif.newPC, 32'h204);
    advance();

    // 5: PC wrap
    set_pc(32'hFFFF_FFFC);
    sample(); check("wrap newPC", bif.newPC, 32'h0); advance();

    // 6: misaligned redirect with no request outstanding
    set_in(1, 1, 32'h82, 0, 0, 1);
    sample();
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign newPC", bif.newPC, 32'h100);
    check("misalign trap", 32'(bif.trap), 32'd1);
`else
    check("misalign newPC", bif.newPC, 32'h80);
    check("misalign trap", 32'(bif.trap), 32'd0);
`endif
    advance();
    set_in(1, 0, 32'h0, 0, 0, 1);
    sample(); check("trap pulse ends", 32'(bif.trap), 32'd0); advance();

    // Reset arriving while a request is outstanding
    set_in(0, 0, 32'h0, 0, 0, 0);
    sample(); advance();
    reset = 1'b1;
    sample();
    check("midreq imem_req", 32'(bif.imem_req), 32'd0);
    check("midreq state", 32'(bif.state), 32'd0);
    advance();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset                = ($urandom_range(0, 249) == 0);
      bif.stall            = ($urandom_range(0, 9) < 3);
      bif.imem_ready       = ($urandom_range(0, 9) < 6);
      bif.redirect_valid   = ($urandom_range(0, 9) == 0);
      bif.redirect_target  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      bif.halt_req         = ($urandom_range(0, 39) == 0);
      bif.resume           = ($urandom_range(0, 4) == 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
